kugelblitz_tx_frame_pad: RTL and testbench

//  TX egress stage between kugelblitz_offload qsfpN_tx_m_axis and the CMAC TX AXIS port, one instance per QSFP.

---
 rtl/kugelblitz_tx_frame_pad_pkg.sv | 14 +
 rtl/kugelblitz_axis_skid.sv | 60 ++++++
 rtl/kugelblitz_tx_frame_pad.sv | 172 +++++++++++++++++
 tb/tb_kugelblitz_tx_frame_pad.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kugelblitz_tx_frame_pad_pkg.sv
// Shared constants and FSM encoding for the kugelblitz TX frame pad stage.
package kugelblitz_tx_frame_pad_pkg;

  localparam int ETH_MIN_FRAME_LEN   = 60;
  localparam int ETH_MAX_JUMBO_LEN   = 9600;
  localparam int TUSER_BAD_FRAME_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } pad_state_e;

endpackage

// File: rtl/kugelblitz_axis_skid.sv
// Registered-ready AXIS skid buffer: an output register backed by one temp register.
module kugelblitz_axis_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] tmp_data_q, tmp_data_d;
  logic             out_valid_q, out_valid_d;
  logic             tmp_valid_q, tmp_valid_d;
  logic             in_ready_q;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tmp_data_d  = tmp_data_q;
    tmp_valid_d = tmp_valid_q;
    if (out_ready_i || !out_valid_q) begin
      if (tmp_valid_q) begin
        out_data_d  = tmp_data_q;
        out_valid_d = 1'b1;
        tmp_valid_d = 1'b0;
      end else begin
        out_data_d  = in_data_i;
        out_valid_d = in_valid_i && in_ready_q;
      end
    end else if (in_valid_i && in_ready_q) begin
      // Output is stalled: park the accepted beat so ready can be registered.
      tmp_data_d  = in_data_i;
      tmp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      tmp_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      tmp_valid_q <= tmp_valid_d;
      in_ready_q  <= !tmp_valid_d;
    end
    out_data_q <= out_data_d;
    tmp_data_q <= tmp_data_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/kugelblitz_tx_frame_pad.sv
// TX egress stage: pads runts, truncates oversize frames, masks unkept bytes.
// Optional statistics counters are built when KUGELBLITZ_PAD_STATS_EN is defined.
module kugelblitz_tx_frame_pad
  import kugelblitz_tx_frame_pad_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 1,
  parameter int MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
  parameter int MAX_FRAME_LEN = ETH_MAX_JUMBO_LEN,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef KUGELBLITZ_PAD_STATS_EN
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  stat_frame_count,
  output logic [CNT_WIDTH-1:0]  stat_pad_count,
  output logic [CNT_WIDTH-1:0]  stat_trunc_count,
`endif
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int LEN_W  = $clog2(MAX_FRAME_LEN + KEEP_WIDTH + 1);
  localparam int BB_W   = $clog2(KEEP_WIDTH + 1);
  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME_LEN);
`ifdef KUGELBLITZ_PAD_STATS_EN
  localparam int SKID_W = BEAT_W + 2;
`else
  localparam int SKID_W = BEAT_W;
`endif

  if (DATA_WIDTH != 512) begin : g_chk_dw
    $error("kugelblitz_tx_frame_pad: only DATA_WIDTH=512 is supported");
  end
  if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_chk_kw
    $error("kugelblitz_tx_frame_pad: KEEP_WIDTH must equal DATA_WIDTH/8");
  end
  if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > KEEP_WIDTH || MAX_FRAME_LEN < MIN_FRAME_LEN) begin : g_chk_len
    $error("kugelblitz_tx_frame_pad: invalid MIN/MAX_FRAME_LEN");
  end
  if (CNT_WIDTH < 1) begin : g_chk_cnt
    $error("kugelblitz_tx_frame_pad: CNT_WIDTH must be positive");
  end

  pad_state_e            state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d, sum, rem;
  logic [BB_W-1:0]       beat_bytes;
  logic                  is_pad, is_over, is_trunc, s_fire;
  logic                  skid_in_ready, skid_in_valid;
  logic [KEEP_WIDTH-1:0] pad_mask, trim_mask, keep_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last_out;
  logic [USER_WIDTH-1:0] user_out;
  logic [SKID_W-1:0]     skid_in, skid_out;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i]) beat_bytes = BB_W'(i + 1);
    end
  end

  assign sum      = len_q + LEN_W'(beat_bytes);
  assign rem      = MAX_L - len_q;
  assign is_pad   = (state_q == ST_IDLE) && s_axis_tlast && (beat_bytes < BB_W'(MIN_FRAME_LEN));
  assign is_over  = sum > MAX_L;
  // A non-last beat landing exactly on MAX already carries the final legal byte.
  assign is_trunc = is_over || ((sum == MAX_L) && !s_axis_tlast);
  assign keep_out = is_pad ? pad_mask : (is_over ? trim_mask : s_axis_tkeep);
  assign last_out = s_axis_tlast || is_trunc;

  for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_byte
    assign pad_mask[gi]         = (gi < MIN_FRAME_LEN);
    assign trim_mask[gi]        = (LEN_W'(gi) < rem);
    assign data_out[gi*8 +: 8]  = (keep_out[gi] && s_axis_tkeep[gi]) ? s_axis_tdata[gi*8 +: 8] : 8'h00;
  end

  always_comb begin
    user_out = s_axis_tuser;
    user_out[TUSER_BAD_FRAME_BIT] = s_axis_tuser[TUSER_BAD_FRAME_BIT] || is_trunc;
  end

  assign s_axis_tready = skid_in_ready || (state_q == ST_DROP);
  assign skid_in_valid = s_axis_tvalid && (state_q != ST_DROP);
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (s_fire) begin
      case (state_q)
        ST_DROP: begin
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: begin
          if (s_axis_tlast || is_trunc) begin
            state_d = (is_trunc && !s_axis_tlast) ? ST_DROP : ST_IDLE;
            len_d   = '0;
          end else begin
            state_d = ST_ACTIVE;
            len_d   = sum;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

`ifdef KUGELBLITZ_PAD_STATS_EN
  logic                 out_pad, out_trunc, m_last_fire;
  logic [CNT_WIDTH-1:0] frame_cnt_q, pad_cnt_q, trunc_cnt_q;

  assign skid_in = {data_out, keep_out, last_out, user_out, is_pad, is_trunc};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, out_pad, out_trunc} = skid_out;
  assign m_last_fire = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      frame_cnt_q <= '0;
      pad_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else if (m_last_fire) begin
      frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      pad_cnt_q   <= pad_cnt_q + CNT_WIDTH'(out_pad);
      trunc_cnt_q <= trunc_cnt_q + CNT_WIDTH'(out_trunc);
    end
  end

  assign stat_frame_count = frame_cnt_q;
  assign stat_pad_count   = pad_cnt_q;
  assign stat_trunc_count = trunc_cnt_q;
`else
  assign skid_in = {data_out, keep_out, last_out, user_out};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;
`endif

  kugelblitz_axis_skid #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (skid_in),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_in_ready),
    .out_data_o  (skid_out),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

endmodule

// File: tb/tb_kugelblitz_tx_frame_pad.sv
// Randomised bench for kugelblitz_tx_frame_pad against a byte-level frame model.
module tb_kugelblitz_tx_frame_pad;

  localparam int DW = 512, KW = 64, UW = 1, MINL = 60, MAXL = 9600, CW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
`ifdef KUGELBLITZ_PAD_STATS_EN
  logic          stat_clear = 1'b0;
  logic [CW-1:0] stat_frame_count, stat_pad_count, stat_trunc_count;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  int    rdy_mode = 0;
  bit    sb_en = 1'b1;
  int    frames_seen = 0;
  int    md_frames = 0, md_pads = 0, md_truncs = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  kugelblitz_tx_frame_pad #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .MIN_FRAME_LEN(MINL), .MAX_FRAME_LEN(MAXL), .CNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef KUGELBLITZ_PAD_STATS_EN
    .stat_clear       (stat_clear),
    .stat_frame_count (stat_frame_count),
    .stat_pad_count   (stat_pad_count),
    .stat_trunc_count (stat_trunc_count),
`endif
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_axis_tready = 1'b1;
    else if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(1, 0));
  end

  // Monitor: inputs only change just after posedge, so negedge values are what the next edge sees.
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_data = '0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst && sb_en) begin
      if (stall_q && m_axis_tvalid) check_eq("stall_data", m_axis_tdata, hold_data);
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq("beat_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("tdata", m_axis_tdata, e.d);
          check_eq("tkeep", DW'(m_axis_tkeep), DW'(e.k));
          check_eq("tlast", DW'(m_axis_tlast), DW'(e.l));
          check_eq("tuser", DW'(m_axis_tuser), DW'(e.u));
          if (e.l) begin
            frames_seen++;
            $display("frame %0d out: last keep %h user %0d", frames_seen, m_axis_tkeep, m_axis_tuser);
          end
        end
      end
    end
    stall_q   <= m_axis_tvalid && !m_axis_tready;
    hold_data <= m_axis_tdata;
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [UW-1:0] u);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check_eq("s_tready_wait", DW'(acc), DW'(1));
    s_axis_tvalid = 1'b0;
  endtask

  // Model: output bytes = input bytes, cut at MAXL (flagged bad), or zero-padded to MINL for 1-beat runts.
  task automatic send_frame(input int n, input logic [UW-1:0] usr);
    int            nb, cnt;
    logic          bad, pad;
    logic [7:0]    fb[$];
    logic [7:0]    ob[$];
    logic [DW-1:0] bd[$];
    logic [KW-1:0] bk[$];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    beat_t         e;
    nb = (n == 0) ? 1 : (n + KW - 1) / KW;
    for (int b = 0; b < nb; b++) begin
      cnt = (n - b * KW > KW) ? KW : n - b * KW;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
      k = '0;
      for (int i = 0; i < cnt; i++) begin
        k[i] = 1'b1;
        fb.push_back(d[i*8 +: 8]);
      end
      bd.push_back(d);
      bk.push_back(k);
    end
    bad = (n > MAXL);
    pad = (nb == 1) && (n < MINL);
    for (int i = 0; i < (bad ? MAXL : n); i++) ob.push_back(fb[i]);
    while (pad && ob.size() < MINL) ob.push_back(8'h00);
    for (int base = 0; base < ob.size(); base += KW) begin
      e.d = '0;
      e.k = '0;
      for (int i = 0; i < KW && base + i < ob.size(); i++) begin
        e.k[i] = 1'b1;
        e.d[i*8 +: 8] = ob[base + i];
      end
      e.l = (base + KW >= ob.size());
      e.u = e.l ? (usr | UW'(bad)) : '0;
      exp_q.push_back(e);
    end
    md_frames++;
    md_pads   += int'(pad);
    md_truncs += int'(bad);
    for (int b = 0; b < nb; b++)
      send_beat(bd[b], bk[b], b == nb - 1, (b == nb - 1) ? usr : '0);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(posedge clk);
      g++;
    end
    check_eq("drain_left", DW'(exp_q.size()), DW'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef KUGELBLITZ_PAD_STATS_EN
    check_eq("stat_frames", DW'(stat_frame_count), DW'(md_frames));
    check_eq("stat_pads",   DW'(stat_pad_count),   DW'(md_pads));
    check_eq("stat_truncs", DW'(stat_trunc_count), DW'(md_truncs));
`endif
  endtask

  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int g;
    // Reset state
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_tready", DW'(s_axis_tready), DW'(0));
    check_eq("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_s_tready", DW'(s_axis_tready), DW'(1));
    check_stats();

    // Runt pad, with one-cycle latency into an empty output
    send_frame(14, 1'b0);
    check_eq("latency_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    wait_drain();
    // Two-beat frame passes unchanged
    send_frame(128, 1'b0);
    wait_drain();
    check_stats();
    // Oversize frame, exact fit, off-by-one, empty and bad-flagged runts
    send_frame(10000, 1'b0);
    send_frame(MAXL, 1'b0);
    send_frame(MAXL + 1, 1'b1);
    send_frame(MAXL + 30, 1'b0);
    send_frame(0, 1'b0);
    send_frame(1, 1'b1);
    send_frame(MINL, 1'b0);
    wait_drain();
    check_stats();

    // Back-to-back random frames under random backpressure
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      if (f % 8 == 7) send_frame($urandom_range(KW, 0), 1'($urandom_range(1, 0)));
      else send_frame($urandom_range(1514, 60), 1'($urandom_range(1, 0)));
    end
    wait_drain();
    check_stats();

    // Reset mid-frame: in-flight data is dropped and the next beat starts a frame
    rdy_mode = 0;
    @(posedge clk);
    #1;
    sb_en = 1'b0;
    send_beat({16{32'hA5A5_5A5A}}, '1, 1'b0, '0);
    send_beat({16{32'h1234_5678}}, '1, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    exp_q.delete();
    md_frames = 0; md_pads = 0; md_truncs = 0;
    check_stats();
    sb_en = 1'b1;
    send_frame(14, 1'b0);
    wait_drain();
    check_stats();

`ifdef KUGELBLITZ_PAD_STATS_EN
    // stat_clear coincident with a padded frame's tlast handshake
    rdy_mode = 2;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    send_frame(20, 1'b0);
    g = 0;
    while (!m_axis_tvalid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq("clr_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    m_axis_tready = 1'b1;
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    m_axis_tready = 1'b0;
    md_frames = 0; md_pads = 0; md_truncs = 0;
    check_stats();
    check_eq("clr_queue_empty", DW'(exp_q.size()), DW'(0));
    rdy_mode = 0;
`endif
    g = 0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("final_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
